// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit accumulator CPU control path:
// opcodes, FSM states, ALU operations and opcode classification.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_LDI   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_PASS = 3'd4
    } alu_op_t;

    // Opcodes that need an operand access through the shared memory port.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) ||
               (op == OP_SUB)  || (op == OP_AND)   || (op == OP_OR);
    endfunction

endpackage

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM: fetch / decode / execute / memory with halt,
// sticky illegal-opcode and memory-timeout detection.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_program,
    input  logic [3:0]       op_code,
    input  logic             acc_zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             acc_load,
    output logic             acc_src,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    // The counter only has to reach MEM_TIMEOUT-1: the edge after that wait ends the access.
    localparam int                WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            cur_state;
    state_t            next_state;
    alu_op_t           alu_sel;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              retire;
    logic              flag_illegal;
    logic              timeout;

    assign state  = cur_state;
    assign halted = (cur_state == S_HALTED);
    assign alu_op = alu_sel;

    always_comb begin
        next_state   = cur_state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        addr_sel     = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        acc_load     = 1'b0;
        acc_src      = 1'b0;
        alu_sel      = ALU_ADD;
        retire       = 1'b0;
        flag_illegal = 1'b0;
        timeout      = 1'b0;
        waiting      = 1'b0;

        if (!rst) begin
            case (cur_state)
                S_FETCH: begin
                    if (!halt_program) begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            ir_load    = 1'b1;
                            pc_inc     = 1'b1;
                            next_state = S_DECODE;
                        end
                    end
                end
                S_DECODE: next_state = S_EXEC;
                S_EXEC: begin
                    next_state = S_FETCH;
                    case (op_code)
                        OP_NOP: retire = 1'b1;
                        OP_LDI: begin
                            acc_load = 1'b1;
                            acc_src  = 1'b1;
                            retire   = 1'b1;
                        end
                        OP_JMP: begin
                            pc_load = 1'b1;
                            retire  = 1'b1;
                        end
                        OP_JZ: begin
                            pc_load = acc_zero;
                            retire  = 1'b1;
                        end
                        OP_HALT: begin
                            retire     = 1'b1;
                            next_state = S_HALTED;
                        end
                        default: begin
                            if (is_mem_op(op_code)) begin
                                next_state = S_MEM;
                            end else begin
                                flag_illegal = 1'b1;
                                retire       = 1'b1;
                            end
                        end
                    endcase
                end
                S_MEM: begin
                    addr_sel  = 1'b1;
                    mem_write = (op_code == OP_STORE);
                    mem_read  = (op_code != OP_STORE);
                    if (mem_ready) begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                        if (op_code != OP_STORE) begin
                            acc_load = 1'b1;
                            case (op_code)
                                OP_ADD:  alu_sel = ALU_ADD;
                                OP_SUB:  alu_sel = ALU_SUB;
                                OP_AND:  alu_sel = ALU_AND;
                                OP_OR:   alu_sel = ALU_OR;
                                default: alu_sel = ALU_PASS;
                            endcase
                        end
                    end
                end
                default: next_state = cur_state;
            endcase

            // A ready arriving on the last allowed wait cycle still wins over the timeout.
            waiting = (mem_read || mem_write) && !mem_ready;
            if (MEM_TIMEOUT != 0 && waiting && wait_cnt == WAIT_LAST) begin
                timeout    = 1'b1;
                next_state = S_HALTED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state   <= S_FETCH;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            bus_error   <= 1'b0;
            instr_count <= '0;
        end else begin
            cur_state <= next_state;
            if (waiting && next_state == cur_state) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
            if (flag_illegal) begin
                illegal_op <= 1'b1;
            end
            if (timeout) begin
                bus_error <= 1'b1;
            end
        end
    end

endmodule
